// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the BRAM port arbiter.
// Tag bundle carried alongside each read until its data returns.
package bram_arb_pkg;

   typedef logic req_id_t;

   typedef struct packed {
      logic    valid;
      req_id_t id;
   } tag_t;

   function automatic int rd_latency(input int pipelined);
      return 1 + pipelined;
   endfunction

endpackage

// File: rtl/BRAM2.sv
// Dual-port read-first block RAM with optional output register.
// Port B writes are applied in the port A process; both clocks share one net.
module BRAM2 #(
   parameter int PIPELINED  = 0,
   parameter int ADDR_WIDTH = 1,
   parameter int DATA_WIDTH = 1,
   parameter int MEMSIZE    = 2 ** ADDR_WIDTH
) (
   input  logic                  CLKA,
   input  logic                  ENA,
   input  logic                  WEA,
   input  logic [ADDR_WIDTH-1:0] ADDRA,
   input  logic [DATA_WIDTH-1:0] DIA,
   output logic [DATA_WIDTH-1:0] DOA,
   input  logic                  CLKB,
   input  logic                  ENB,
   input  logic                  WEB,
   input  logic [ADDR_WIDTH-1:0] ADDRB,
   input  logic [DATA_WIDTH-1:0] DIB,
   output logic [DATA_WIDTH-1:0] DOB
);

   logic [DATA_WIDTH-1:0] ram [MEMSIZE];
   logic [DATA_WIDTH-1:0] doa_r;
   logic [DATA_WIDTH-1:0] doa_r2;
   logic [DATA_WIDTH-1:0] dob_r;
   logic [DATA_WIDTH-1:0] dob_r2;

   // Port A read-first access; also commits port B writes.
   always_ff @(posedge CLKA) begin
      if (ENA) begin
         doa_r <= ram[ADDRA];
         if (WEA)
            ram[ADDRA] <= DIA;
      end
      if (ENB && WEB)
         ram[ADDRB] <= DIB;
      doa_r2 <= doa_r;
   end

   // Port B read-first output path.
   always_ff @(posedge CLKB) begin
      if (ENB)
         dob_r <= ram[ADDRB];
      dob_r2 <= dob_r;
   end

   assign DOA = (PIPELINED != 0) ? doa_r2 : doa_r;
   assign DOB = (PIPELINED != 0) ? dob_r2 : dob_r;

endmodule

// File: rtl/bram_rsp_tag_pipe.sv
// Read-tag delay line matching BRAM latency.
// Last stage is decoded into per-requester response strobes.
module bram_rsp_tag_pipe
   import bram_arb_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic CLK,
   input  logic RST,
   input  tag_t TAG_IN,
   output logic RSP0_VALID,
   output logic RSP1_VALID
);

   tag_t stage [DEPTH];

   // Shift tags one stage per cycle; reset drops everything in flight.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++)
            stage[i] <= '0;
      end else begin
         stage[0] <= TAG_IN;
         for (int i = 1; i < DEPTH; i++)
            stage[i] <= stage[i-1];
      end
   end

   assign RSP0_VALID = stage[DEPTH-1].valid
                     && (stage[DEPTH-1].id == 1'b0);
   assign RSP1_VALID = stage[DEPTH-1].valid
                     && (stage[DEPTH-1].id == 1'b1);

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin sharing of one BRAM port between two requesters.
// Read data is routed back using a tag pipe matched to BRAM latency.
module bram_port_arbiter
   import bram_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 1,
   parameter int DATA_WIDTH = 1,
   parameter int PIPELINED  = 0
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  REQ0_VALID,
   output logic                  REQ0_READY,
   input  logic                  REQ0_WE,
   input  logic [ADDR_WIDTH-1:0] REQ0_ADDR,
   input  logic [DATA_WIDTH-1:0] REQ0_DATA,
   input  logic                  REQ1_VALID,
   output logic                  REQ1_READY,
   input  logic                  REQ1_WE,
   input  logic [ADDR_WIDTH-1:0] REQ1_ADDR,
   input  logic [DATA_WIDTH-1:0] REQ1_DATA,
   output logic                  RSP0_VALID,
   output logic [DATA_WIDTH-1:0] RSP0_DATA,
   output logic                  RSP1_VALID,
   output logic [DATA_WIDTH-1:0] RSP1_DATA,
   output logic                  BRAM_EN,
   output logic                  BRAM_WE,
   output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
   output logic [DATA_WIDTH-1:0] BRAM_DI,
   input  logic [DATA_WIDTH-1:0] BRAM_DO
);

   localparam int L = rd_latency(PIPELINED);

   req_id_t last;
   req_id_t win;
   logic    gnt0;
   logic    gnt1;
   tag_t    tag_in;
   logic    pipe_rsp0;
   logic    pipe_rsp1;

   assign gnt0 = !RST && REQ0_VALID
              && (!REQ1_VALID || (last == 1'b1));
   assign gnt1 = !RST && REQ1_VALID
              && (!REQ0_VALID || (last == 1'b0));

   assign REQ0_READY = gnt0;
   assign REQ1_READY = gnt1;

   // Remember the latest winner so contention alternates.
   always_ff @(posedge CLK) begin
      if (RST)
         last <= 1'b1;
      else if (gnt0 || gnt1)
         last <= win;
   end

   // Steer the winning request onto the BRAM pins; idle pins are zero.
   always_comb begin
      BRAM_EN   = 1'b0;
      BRAM_WE   = 1'b0;
      BRAM_ADDR = '0;
      BRAM_DI   = '0;
      win       = last;
      unique case (1'b1)
         gnt0: begin
            BRAM_EN   = 1'b1;
            BRAM_WE   = REQ0_WE;
            BRAM_ADDR = REQ0_ADDR;
            BRAM_DI   = REQ0_DATA;
            win       = 1'b0;
         end
         gnt1: begin
            BRAM_EN   = 1'b1;
            BRAM_WE   = REQ1_WE;
            BRAM_ADDR = REQ1_ADDR;
            BRAM_DI   = REQ1_DATA;
            win       = 1'b1;
         end
         default: ;
      endcase
   end

   assign tag_in = '{valid: BRAM_EN && !BRAM_WE, id: win};

   bram_rsp_tag_pipe #(
      .DEPTH (L)
   ) u_tag_pipe (
      .CLK        (CLK),
      .RST        (RST),
      .TAG_IN     (tag_in),
      .RSP0_VALID (pipe_rsp0),
      .RSP1_VALID (pipe_rsp1)
   );

   assign RSP0_VALID = pipe_rsp0 && !RST;
   assign RSP1_VALID = pipe_rsp1 && !RST;
   assign RSP0_DATA  = BRAM_DO;
   assign RSP1_DATA  = BRAM_DO;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Randomized bench for bram_port_arbiter, latency 1 and 2 side by side.
// Both arbiters see identical traffic and are checked against one memory model.
module tb_bram_port_arbiter;

   localparam int AW = 4;
   localparam int DW = 8;

   typedef struct {
      int            due;
      logic          id;
      logic [DW-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          v0, we0, v1, we1;
   logic [AW-1:0] a0, a1;
   logic [DW-1:0] d0, d1;

   logic [1:0]         rdy0, rdy1, rv0, rv1, ben, bwe;
   logic [1:0][AW-1:0] badr;
   logic [1:0][DW-1:0] bdi, bdo, rsp0d, rsp1d, dob;

   bram_port_arbiter #(
      .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .PIPELINED (0)
   ) u_arb0 (
      .CLK (clk), .RST (rst),
      .REQ0_VALID (v0), .REQ0_READY (rdy0[0]), .REQ0_WE (we0),
      .REQ0_ADDR (a0), .REQ0_DATA (d0),
      .REQ1_VALID (v1), .REQ1_READY (rdy1[0]), .REQ1_WE (we1),
      .REQ1_ADDR (a1), .REQ1_DATA (d1),
      .RSP0_VALID (rv0[0]), .RSP0_DATA (rsp0d[0]),
      .RSP1_VALID (rv1[0]), .RSP1_DATA (rsp1d[0]),
      .BRAM_EN (ben[0]), .BRAM_WE (bwe[0]), .BRAM_ADDR (badr[0]),
      .BRAM_DI (bdi[0]), .BRAM_DO (bdo[0])
   );

   BRAM2 #(
      .PIPELINED (0), .ADDR_WIDTH (AW), .DATA_WIDTH (DW)
   ) u_ram0 (
      .CLKA (clk), .ENA (ben[0]), .WEA (bwe[0]), .ADDRA (badr[0]),
      .DIA (bdi[0]), .DOA (bdo[0]),
      .CLKB (clk), .ENB (1'b0), .WEB (1'b0), .ADDRB ('0),
      .DIB ('0), .DOB (dob[0])
   );

   bram_port_arbiter #(
      .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .PIPELINED (1)
   ) u_arb1 (
      .CLK (clk), .RST (rst),
      .REQ0_VALID (v0), .REQ0_READY (rdy0[1]), .REQ0_WE (we0),
      .REQ0_ADDR (a0), .REQ0_DATA (d0),
      .REQ1_VALID (v1), .REQ1_READY (rdy1[1]), .REQ1_WE (we1),
      .REQ1_ADDR (a1), .REQ1_DATA (d1),
      .RSP0_VALID (rv0[1]), .RSP0_DATA (rsp0d[1]),
      .RSP1_VALID (rv1[1]), .RSP1_DATA (rsp1d[1]),
      .BRAM_EN (ben[1]), .BRAM_WE (bwe[1]), .BRAM_ADDR (badr[1]),
      .BRAM_DI (bdi[1]), .BRAM_DO (bdo[1])
   );

   BRAM2 #(
      .PIPELINED (1), .ADDR_WIDTH (AW), .DATA_WIDTH (DW)
   ) u_ram1 (
      .CLKA (clk), .ENA (ben[1]), .WEA (bwe[1]), .ADDRA (badr[1]),
      .DIA (bdi[1]), .DOA (bdo[1]),
      .CLKB (clk), .ENB (1'b0), .WEB (1'b0), .ADDRB ('0),
      .DIB ('0), .DOB (dob[1])
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [DW-1:0] mem [16];
   int   last_m;
   exp_t q0[$];
   exp_t q1[$];
   int   deny0[2];
   int   deny1[2];

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic rsp_check(input string nm,
                            ref exp_t q[$],
                            input logic r0, input logic r1,
                            input logic [DW-1:0] dd0,
                            input logic [DW-1:0] dd1);
      logic          e0;
      logic          e1;
      logic [DW-1:0] ed;
      e0 = 1'b0;
      e1 = 1'b0;
      ed = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
         e0 = (q[0].id == 1'b0);
         e1 = (q[0].id == 1'b1);
         ed = q[0].data;
         void'(q.pop_front());
      end
      chk($sformatf("%s rsp0_valid c%0d", nm, cyc), r0, e0);
      chk($sformatf("%s rsp1_valid c%0d", nm, cyc), r1, e1);
      if (e0)
         chk($sformatf("%s rsp0_data c%0d", nm, cyc), dd0, ed);
      if (e1)
         chk($sformatf("%s rsp1_data c%0d", nm, cyc), dd1, ed);
   endtask

   task automatic step(input logic r,
                       input logic iv0, input logic iwe0,
                       input logic [AW-1:0] ia0,
                       input logic [DW-1:0] id0,
                       input logic iv1, input logic iwe1,
                       input logic [AW-1:0] ia1,
                       input logic [DW-1:0] id1);
      logic          g0;
      logic          g1;
      logic          xwe;
      logic [AW-1:0] xa;
      logic [DW-1:0] xd;
      exp_t          e;
      rst = r;
      v0 = iv0; we0 = iwe0; a0 = ia0; d0 = id0;
      v1 = iv1; we1 = iwe1; a1 = ia1; d1 = id1;
      g0 = !r && iv0 && (!iv1 || last_m == 1);
      g1 = !r && iv1 && (!iv0 || last_m == 0);
      xwe = g0 ? iwe0 : (g1 ? iwe1 : 1'b0);
      xa  = g0 ? ia0 : (g1 ? ia1 : '0);
      xd  = g0 ? id0 : (g1 ? id1 : '0);
      @(negedge clk);
      if (r) begin
         q0.delete();
         q1.delete();
      end
      rsp_check("L1", q0, rv0[0], rv1[0], rsp0d[0], rsp1d[0]);
      rsp_check("L2", q1, rv0[1], rv1[1], rsp0d[1], rsp1d[1]);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("L%0d ready0 c%0d", k + 1, cyc), rdy0[k], g0);
         chk($sformatf("L%0d ready1 c%0d", k + 1, cyc), rdy1[k], g1);
         chk($sformatf("L%0d en c%0d", k + 1, cyc), ben[k], g0 | g1);
         chk($sformatf("L%0d we c%0d", k + 1, cyc), bwe[k], xwe);
         chk($sformatf("L%0d addr c%0d", k + 1, cyc), badr[k], xa);
         chk($sformatf("L%0d di c%0d", k + 1, cyc), bdi[k], xd);
         deny0[k] = (!r && iv0 && !rdy0[k]) ? deny0[k] + 1 : 0;
         deny1[k] = (!r && iv1 && !rdy1[k]) ? deny1[k] + 1 : 0;
         chk($sformatf("L%0d starve0 c%0d", k + 1, cyc),
             32'(deny0[k] <= 1), 32'd1);
         chk($sformatf("L%0d starve1 c%0d", k + 1, cyc),
             32'(deny1[k] <= 1), 32'd1);
      end
      if (r) begin
         last_m = 1;
      end else if (g0 || g1) begin
         if (!xwe) begin
            e.id   = g1;
            e.data = mem[xa];
            e.due  = cyc + 1;
            q0.push_back(e);
            e.due  = cyc + 2;
            q1.push_back(e);
         end else begin
            mem[xa] = xd;
         end
         last_m = g1 ? 1 : 0;
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
   endtask

   initial begin
      logic [DW-1:0] dv;
      rst = 1'b1;
      v0 = 1'b0; we0 = 1'b0; a0 = '0; d0 = '0;
      v1 = 1'b0; we1 = 1'b0; a1 = '0; d1 = '0;
      last_m = 1;
      for (int k = 0; k < 2; k++) begin
         deny0[k] = 0;
         deny1[k] = 0;
      end
      for (int i = 0; i < 16; i++)
         mem[i] = '0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++)
         step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);

      for (int i = 0; i < 16; i++) begin
         dv = DW'($urandom);
         if (i == 1) dv = 8'h11;
         if (i == 2) dv = 8'h22;
         if (i == 5) dv = 8'h5C;
         if (i == 7) dv = 8'h00;
         step(1'b0, 1'b1, 1'b1, AW'(i), dv, 1'b0, 1'b0, '0, '0);
      end
      idle(1);

      step(1'b0, 1'b1, 1'b1, 4'd3, 8'hA5, 1'b0, 1'b0, '0, '0);
      step(1'b0, 1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b0, '0, '0);
      idle(3);

      for (int i = 0; i < 6; i++)
         step(1'b0, 1'b1, 1'b0, 4'd1, '0, 1'b1, 1'b0, 4'd2, '0);
      idle(3);

      step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 4'd5, '0);
      idle(3);

      step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
      step(1'b0, 1'b1, 1'b1, 4'd7, 8'h77, 1'b1, 1'b0, 4'd7, '0);
      step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 4'd7, '0);
      idle(3);

      step(1'b0, 1'b1, 1'b0, 4'd1, '0, 1'b0, 1'b0, '0, '0);
      step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 4'd2, '0);
      step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
      step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
      step(1'b0, 1'b1, 1'b0, 4'd3, '0, 1'b1, 1'b0, 4'd4, '0);
      idle(3);

      for (int i = 0; i < 12; i++)
         step(1'b0, 1'(i % 2), 1'b0, AW'($urandom), '0,
              1'b1, 1'b0, AW'($urandom), '0);
      idle(3);

      for (int i = 0; i < 3000; i++)
         step(($urandom_range(0, 63) == 0),
              1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom),
              1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom));
      idle(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
